// File: rtl/alu_mul_seq.sv
// Shares one 64-bit ALU between the datapath and a shift-and-add multiplier.
// The multiplier borrows the ALU for one ADD per multiplier bit and stalls the datapath meanwhile.
//
// state | meaning
// IDLE  | ALU passthrough, waiting for Start
// RUN   | multiplier owns the ALU, datapath stalled
// DONE  | Done pulse, Product valid, passthrough restored
module alu_mul_seq (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic [63:0] DpA,
  input  logic [63:0] DpB,
  input  logic [3:0]  DpCtrl,
  output logic        DpStall,
  input  logic        Start,
  input  logic [63:0] MulA,
  input  logic [63:0] MulB,
  output logic        Ready,
  output logic        Done,
  output logic [63:0] Product,
  output logic [63:0] AluA,
  output logic [63:0] AluB,
  output logic [3:0]  AluCtrl,
  input  logic [63:0] AluW
);

  localparam logic [3:0] CTRL_ADD = 4'b0010;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] mcand_q, mcand_d;
  logic [63:0] mplier_q, mplier_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        run;

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_RUN: begin
        acc_d    = AluW;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 6'd1;
        // Stop once the last remaining multiplier bit has been consumed.
        if ((mplier_q[63:1] == 63'd0) || (cnt_q == 6'd63)) begin
          state_d = S_DONE;
        end
      end
      default: begin
        if (Start) begin
          acc_d    = '0;
          mcand_d  = MulA;
          mplier_d = MulB;
          cnt_d    = '0;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    run     = (state_q == S_RUN);
    DpStall = run;
    Ready   = !run;
    Done    = (state_q == S_DONE);
    Product = acc_q;
    if (run) begin
      AluA    = acc_q;
      AluB    = mplier_q[0] ? mcand_q : 64'd0;
      AluCtrl = CTRL_ADD;
    end else begin
      AluA    = DpA;
      AluB    = DpB;
      AluCtrl = DpCtrl;
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with a behavioural ALU and a product scoreboard.
module tb_alu_mul_seq;

  logic        CLK;
  logic        Reset_L;
  logic [63:0] DpA, DpB;
  logic [3:0]  DpCtrl;
  logic        DpStall;
  logic        Start;
  logic [63:0] MulA, MulB;
  logic        Ready, Done;
  logic [63:0] Product;
  logic [63:0] AluA, AluB;
  logic [3:0]  AluCtrl;
  logic [63:0] AluW;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb[$];

  alu_mul_seq dut (
    .CLK(CLK), .Reset_L(Reset_L), .DpA(DpA), .DpB(DpB), .DpCtrl(DpCtrl),
    .DpStall(DpStall), .Start(Start), .MulA(MulA), .MulB(MulB),
    .Ready(Ready), .Done(Done), .Product(Product),
    .AluA(AluA), .AluB(AluB), .AluCtrl(AluCtrl), .AluW(AluW)
  );

  always_comb begin
    case (AluCtrl)
      4'b0000: AluW = AluA & AluB;
      4'b0001: AluW = AluA | AluB;
      4'b0010: AluW = AluA + AluB;
      4'b0110: AluW = AluA - AluB;
      4'b0111: AluW = AluB;
      default: AluW = 64'd0;
    endcase
  end

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic int exp_n(input logic [63:0] b);
    int n = 1;
    for (int i = 0; i < 64; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  // Runs one multiply from IDLE; reports latency, stall count and RUN-cycle ALU operand mismatches.
  task automatic do_mul(input logic [63:0] a, input logic [63:0] b,
                        output int lat, output int stall, output int bad,
                        output logic [63:0] prod, output bit timeout);
    logic [63:0] mc, mp, ac, eb;
    mc = a; mp = b; ac = '0;
    lat = 0; stall = 0; bad = 0; prod = '0; timeout = 1'b1;
    MulA = a; MulB = b; Start = 1'b1;
    sb.push_back(a * b);
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    for (int i = 0; i < 80; i++) begin
      lat++;
      if (Done === 1'b1) begin
        prod = Product;
        timeout = 1'b0;
        break;
      end
      if (DpStall === 1'b1) stall++;
      eb = mp[0] ? mc : 64'd0;
      if (AluA !== ac || AluB !== eb || AluCtrl !== 4'b0010 || Ready !== 1'b0) bad++;
      ac = ac + eb;
      mc = mc << 1;
      mp = mp >> 1;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    Reset_L = 1'b0; Start = 1'b0; MulA = '0; MulB = '0;
    DpA = {$urandom, $urandom}; DpB = {$urandom, $urandom}; DpCtrl = 4'b0110;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", Ready); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", Done); end
    checks++; if (Product !== 64'd0) begin errors++; $display("FAIL reset_product got=%h want=0", Product); end
    checks++; if (DpStall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", DpStall); end
    checks++; if (AluA !== DpA || AluB !== DpB) begin errors++; $display("FAIL reset_alu_ab got=%h/%h want=%h/%h", AluA, AluB, DpA, DpB); end
    checks++; if (AluCtrl !== 4'b0110) begin errors++; $display("FAIL reset_alu_ctrl got=%b want=0110", AluCtrl); end
    DpCtrl = 4'b0001;
    #1;
    checks++; if (AluCtrl !== 4'b0001) begin errors++; $display("FAIL reset_ctrl_comb got=%b want=0001", AluCtrl); end
    Reset_L = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_small;
    int lat, stall, bad; logic [63:0] prod, want; bit to;
    DpA = {$urandom, $urandom}; DpB = {$urandom, $urandom}; DpCtrl = 4'b0111;
    #1;
    checks++; if (AluA !== DpA || AluB !== DpB || AluCtrl !== 4'b0111) begin errors++; $display("FAIL idle_passthrough got=%h/%h/%b", AluA, AluB, AluCtrl); end
    do_mul(64'd3, 64'd5, lat, stall, bad, prod, to);
    checks++; if (to) begin errors++; $display("FAIL small_timeout got=no_done want=done"); end
    want = sb.pop_front();
    checks++; if (prod !== want || want !== 64'd15) begin errors++; $display("FAIL small_product got=%0d want=15", prod); end
    checks++; if (stall !== 3) begin errors++; $display("FAIL small_stall got=%0d want=3", stall); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL small_latency got=%0d want=4", lat); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL small_run_alu got=%0d_bad want=0", bad); end
    @(negedge CLK);
    checks++; if (Done !== 1'b0 || Ready !== 1'b1) begin errors++; $display("FAIL small_done_pulse got=done%b/ready%b want=0/1", Done, Ready); end
    checks++; if (Product !== 64'd15) begin errors++; $display("FAIL small_retention got=%0d want=15", Product); end
  endtask

  task automatic test_zero;
    int lat, stall, bad; logic [63:0] prod, want; bit to;
    do_mul(64'h1234, 64'd0, lat, stall, bad, prod, to);
    want = sb.pop_front();
    checks++; if (to || prod !== want) begin errors++; $display("FAIL zero_product got=%h want=%h", prod, want); end
    checks++; if (lat !== 2 || stall !== 1) begin errors++; $display("FAIL zero_timing got=lat%0d/stall%0d want=2/1", lat, stall); end
    @(negedge CLK);
  endtask

  task automatic test_signed;
    int lat, stall, bad; logic [63:0] prod, want; bit to;
    do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd7, lat, stall, bad, prod, to);
    want = sb.pop_front();
    checks++; if (to || prod !== want || want !== 64'hFFFF_FFFF_FFFF_FFF9) begin errors++; $display("FAIL neg_by_7 got=%h want=fffffffffffffff9", prod); end
    checks++; if (stall !== 3 || bad !== 0) begin errors++; $display("FAIL neg_by_7_run got=stall%0d/bad%0d want=3/0", stall, bad); end
    @(negedge CLK);
    do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat, stall, bad, prod, to);
    want = sb.pop_front();
    checks++; if (to || prod !== want || want !== 64'd1) begin errors++; $display("FAIL ones_by_ones got=%h want=1", prod); end
    checks++; if (stall !== 64 || lat !== 65) begin errors++; $display("FAIL ones_by_ones_timing got=stall%0d/lat%0d want=64/65", stall, lat); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL ones_by_ones_alu got=%0d_bad want=0", bad); end
    @(negedge CLK);
  endtask

  task automatic test_random;
    int lat, stall, bad, n; logic [63:0] prod, want, a, b; bit to;
    for (int k = 0; k < 4; k++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(63, 0);
      n = exp_n(b);
      do_mul(a, b, lat, stall, bad, prod, to);
      want = sb.pop_front();
      checks++; if (to || prod !== want) begin errors++; $display("FAIL rand_product got=%h want=%h", prod, want); end
      checks++; if (stall !== n || lat !== n + 1 || bad !== 0) begin errors++; $display("FAIL rand_timing got=stall%0d/lat%0d/bad%0d want=%0d/%0d/0", stall, lat, bad, n, n + 1); end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset_mid_run;
    int seen;
    MulA = 64'd3; MulB = 64'h8000_0000_0000_0000; Start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    repeat (9) @(negedge CLK);
    checks++; if (DpStall !== 1'b1) begin errors++; $display("FAIL midrun_in_run got=%b want=1", DpStall); end
    Reset_L = 1'b0;
    @(negedge CLK);
    checks++; if (Ready !== 1'b1 || DpStall !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL midrun_idle got=ready%b/stall%b/done%b want=1/0/0", Ready, DpStall, Done); end
    checks++; if (Product !== 64'd0) begin errors++; $display("FAIL midrun_product got=%h want=0", Product); end
    Reset_L = 1'b1;
    seen = 0;
    repeat (70) begin
      @(negedge CLK);
      if (Done === 1'b1 || DpStall === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrun_no_done got=%0d want=0", seen); end
  endtask

  task automatic test_back_to_back;
    int lat;
    bit got;
    MulA = 64'd6; MulB = 64'd7; Start = 1'b1;
    sb.push_back(64'd42);
    sb.push_back(64'd81);
    @(posedge CLK);
    @(negedge CLK);
    lat = 1; got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (Done === 1'b1) begin got = 1'b1; break; end
      lat++;
      @(negedge CLK);
    end
    checks++; if (!got || lat !== 4) begin errors++; $display("FAIL b2b_first_done got=lat%0d want=4", lat); end
    checks++; if (Product !== sb.pop_front()) begin errors++; $display("FAIL b2b_first_product got=%0d want=42", Product); end
    MulA = 64'd9; MulB = 64'd9;
    @(negedge CLK);
    checks++; if (DpStall !== 1'b1 || Done !== 1'b0) begin errors++; $display("FAIL b2b_no_bubble got=stall%b/done%b want=1/0", DpStall, Done); end
    Start = 1'b0;
    lat = 1; got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (Done === 1'b1) begin got = 1'b1; break; end
      lat++;
      @(negedge CLK);
    end
    checks++; if (!got || lat !== 5) begin errors++; $display("FAIL b2b_second_done got=lat%0d want=5", lat); end
    checks++; if (Product !== sb.pop_front()) begin errors++; $display("FAIL b2b_second_product got=%0d want=81", Product); end
    @(negedge CLK);
  endtask

  initial begin
    Reset_L = 1'b0; Start = 1'b0; MulA = '0; MulB = '0;
    DpA = '0; DpB = '0; DpCtrl = 4'b0000;
    @(negedge CLK);
    test_reset();
    test_small();
    test_zero();
    test_signed();
    test_random();
    test_reset_mid_run();
    test_back_to_back();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
